mcu_spi_master: RTL
===================

# mcu_spi_master

Parametrised successor to the fixed SPI/GPIO peripheral: a full-duplex SPI master with programmable clock divider, all four CPOL/CPHA modes, MSB/LSB-first selection, multiple chip selects and TX/RX FIFOs. It sits on the 3-bit peripheral memory bus in the 0xFxxx window beside the GPIO block and is driven by the CPU through byte-wide registers.

## Interface
- DIV_WIDTH, 8: width of the divider register, 1..8.
- CS_COUNT, 2: number of active-low chip selects, 1..8.
- FIFO_DEPTH, 4: entries per TX and RX FIFO; power of two, 2..8.
- clk_in  input  1  system clock; all logic on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- sclk_out  output  1  SPI clock.
- mosi_out  output  1  SPI data out.
- miso_in  input  1  SPI data in; 2-FF synchronised internally.
- cs_out  output  CS_COUNT  chip selects, direct from the CS register.
- periph_data_in  input  8  write data.
- periph_addr_in  input  3  register address.
- periph_addr_valid_in  input  1  access strobe, one cycle per access.
- periph_write_en_in  input  1  1 = write, 0 = read.
- periph_data_out  output  8  read data.
- periph_data_valid_out  output  1  read data valid.
- irq_out  output  1  interrupt; only present with SPI_IRQ_EN.

## Operation
- Register map (addr): 0 DIV (RW, bits [DIV_WIDTH-1:0], upper bits read 0); 1 MODE (RW, bit0 CPHA, bit1 CPOL, bit2 LSB_FIRST); 2 CS (RW, bits [CS_COUNT-1:0]); 3 STATUS (R: bit0 busy, bit1 tx_full, bit2 rx_empty, bit3 rx_ovf, bit4 tx_ovf; W: writing 1 to bit3/bit4 clears that flag); 4 TXDATA (W: push); 5 RXDATA (R: pop); 6 LEVEL (R: {rx_count[3:0], tx_count[3:0]}); 7 IRQ_EN (RW with SPI_IRQ_EN, otherwise reads 0x00 and ignores writes).
- Unmapped read fields and write-only addresses read 0x00.
- TX write when full: data dropped, tx_ovf set. RX read when empty: returns 0x00 and does not pop.
- Engine FSM: IDLE -> LOAD when TX not empty. LOAD pops TX and latches DIV, MODE and the shift word -> SHIFT. SHIFT runs 16 half-periods, each lasting DIV+1 clocks -> DONE. DONE pushes the received byte to RX -> IDLE.
- If RX is full at DONE: byte discarded, rx_ovf set.
- CPOL sets the idle level of sclk_out.
- CPHA=0: first bit presented on entering SHIFT; MISO sampled on leading edges, MOSI shifted on trailing edges.
- CPHA=1: MOSI shifted on leading edges, MISO sampled on trailing edges.
- LSB_FIRST selects the shift direction for both MOSI and MISO.
- DIV/MODE writes during a transfer take effect at the next LOAD.
- CS is never changed by the engine.
- busy = (state != IDLE) or TX not empty.
- FIFO push and pop in the same cycle leave the count unchanged.

## Timing
- Reset values: sclk_out 0; mosi_out 0; cs_out all 1; periph_data_out 0x00; periph_data_valid_out 0; irq_out 0.
- Registers after reset: DIV 0, MODE 0, both FIFOs empty, flags clear, FSM IDLE.
- Reset mid-transfer aborts the transfer in the next cycle and discards FIFO contents.
- Read: periph_data_valid_out high exactly one cycle after the strobe, with data. A write drives valid low.
- RXDATA pop takes effect in the strobe cycle.
- TX push at cycle T: LOAD at T+1, SHIFT at T+2.
- First SCLK edge at T+2+DIV+1.
- DONE follows 16*(DIV+1) SHIFT cycles; RX count increments the cycle after DONE.
- Back-to-back bytes: exactly 2 clocks (DONE, LOAD) between the last edge of one byte and the SHIFT entry of the next. sclk_out holds CPOL during that gap.
- MISO sampling uses the synchronised value, 2 clocks late. Correct capture is guaranteed for DIV >= 2.

## Configuration
- SPI_IRQ_EN defined: irq_out port and IRQ_EN register are present. IRQ_EN bit0 enables an RX-not-empty interrupt; bit1 enables a TX-empty-and-IDLE interrupt.
- irq_out is registered and level-type: the OR of the enabled conditions, updated one cycle after the condition changes.
- SPI_IRQ_EN undefined: no irq_out port; address 7 reads 0x00.

## Test plan
- Reset -> cs_out all 1, sclk_out 0, STATUS reads 0x04, LEVEL reads 0x00.
- DIV=2, MODE=0, CS=0x2, write TXDATA 0xA5 with miso looping back mosi -> MOSI bits 1,0,1,0,0,1,0,1; each SCLK half-period is 3 clocks; RXDATA reads 0xA5; STATUS busy clears.
- Repeat with all 4 MODE values, plus MODE=0x4 with TX 0x01 -> correct idle level and edges per mode; LSB_FIRST sends bit0 first.
- Push FIFO_DEPTH+1 bytes while busy -> extra byte dropped, STATUS bit4 set; writing 0x10 to STATUS clears bit4.
- Run FIFO_DEPTH+1 transfers without reading RX -> rx_ovf set; first FIFO_DEPTH bytes read back in order; the next RX read returns 0x00.
- With SPI_IRQ_EN, IRQ_EN=0x01, one transfer -> irq_out rises one cycle after the RX count becomes 1 and falls after the RXDATA read. Assert reset mid-byte -> sclk_out 0 and FSM IDLE on the next cycle.

Source files
------------

// File: rtl/mcu_spi_master_if.sv
// Peripheral memory bus bundle between the CPU side (master) and the SPI master block (slave).
interface mcu_spi_master_if;
  logic [7:0] periph_data_in;
  logic [2:0] periph_addr_in;
  logic       periph_addr_valid_in;
  logic       periph_write_en_in;
  logic [7:0] periph_data_out;
  logic       periph_data_valid_out;

  modport master (
    output periph_data_in, periph_addr_in, periph_addr_valid_in, periph_write_en_in,
    input  periph_data_out, periph_data_valid_out
  );

  modport slave (
    input  periph_data_in, periph_addr_in, periph_addr_valid_in, periph_write_en_in,
    output periph_data_out, periph_data_valid_out
  );
endinterface

// File: rtl/mcu_spi_master.sv
// Full-duplex SPI master with divider, CPOL/CPHA, bit order, chip selects and TX/RX FIFOs.
// Optional feature macro: SPI_IRQ_EN adds the irq_out port and the IRQ_EN register.
module mcu_spi_master #(
  parameter int DIV_WIDTH  = 8,
  parameter int CS_COUNT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_in,
  input  logic                reset_in,
  mcu_spi_master_if.slave     bus,
  output logic                sclk_out,
  output logic                mosi_out,
  input  logic                miso_in,
  output logic [CS_COUNT-1:0] cs_out
`ifdef SPI_IRQ_EN
  ,
  output logic                irq_out
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t               state_q;
  logic [DIV_WIDTH-1:0] div_q, engDiv_q, divCnt_q;
  logic [2:0]           mode_q, engMode_q;
  logic [CS_COUNT-1:0]  cs_q;
  logic                 rxOvf_q, txOvf_q;
  logic [7:0]           dataOut_q;
  logic                 dataValid_q;
  logic [3:0]           edgeCnt_q;
  logic [7:0]           txShift_q, rxShift_q;
  logic                 sclk_q, mosi_q, misoMeta_q, misoSync_q;

  logic [7:0]           txMem_q [FIFO_DEPTH];
  logic [7:0]           rxMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     txWr_q, txRd_q, rxWr_q, rxRd_q;
  logic [CNT_W-1:0]     txCount_q, rxCount_q, txCount_d, rxCount_d;

  logic       wrStrobe, rdStrobe;
  logic       txFull, txEmpty, rxFull, rxEmpty, busy;
  logic       txPushReq, txPush, txPop, rxPush, rxPop, statusWr;
  logic [7:0] txHead, rxHead, rdData, divRd, csRd, irqRd;
  logic [3:0] txLvl, rxLvl;
  logic       leading, doSample, doShift;

  assign wrStrobe  = bus.periph_addr_valid_in && bus.periph_write_en_in;
  assign rdStrobe  = bus.periph_addr_valid_in && !bus.periph_write_en_in;
  assign txFull    = (txCount_q == DEPTH_C);
  assign txEmpty   = (txCount_q == '0);
  assign rxFull    = (rxCount_q == DEPTH_C);
  assign rxEmpty   = (rxCount_q == '0);
  assign busy      = (state_q != IDLE) || !txEmpty;
  assign txPushReq = wrStrobe && (bus.periph_addr_in == 3'd4);
  assign txPush    = txPushReq && !txFull;
  assign txPop     = (state_q == LOAD);
  assign rxPush    = (state_q == DONE) && !rxFull;
  assign rxPop     = rdStrobe && (bus.periph_addr_in == 3'd5) && !rxEmpty;
  assign statusWr  = wrStrobe && (bus.periph_addr_in == 3'd3);
  assign txHead    = txMem_q[txRd_q];
  assign rxHead    = rxMem_q[rxRd_q];

  // Edge 0 of each SCLK pair is the leading edge; CPHA picks which edge samples.
  assign leading  = ~edgeCnt_q[0];
  assign doSample = leading ^ engMode_q[0];
  assign doShift  = !doSample && !((edgeCnt_q == 4'd15) && !engMode_q[0]);

  always_comb begin
    txCount_d = txCount_q;
    if (txPush && !txPop)
      txCount_d = txCount_q + 1'b1;
    else if (!txPush && txPop)
      txCount_d = txCount_q - 1'b1;
    rxCount_d = rxCount_q;
    if (rxPush && !rxPop)
      rxCount_d = rxCount_q + 1'b1;
    else if (!rxPush && rxPop)
      rxCount_d = rxCount_q - 1'b1;
  end

  always_comb begin
    divRd = '0;
    divRd[DIV_WIDTH-1:0] = div_q;
    csRd = '0;
    csRd[CS_COUNT-1:0] = cs_q;
    txLvl = '0;
    txLvl[CNT_W-1:0] = txCount_q;
    rxLvl = '0;
    rxLvl[CNT_W-1:0] = rxCount_q;
    rdData = 8'h00;
    case (bus.periph_addr_in)
      3'd0:    rdData = divRd;
      3'd1:    rdData = {5'b0, mode_q};
      3'd2:    rdData = csRd;
      3'd3:    rdData = {3'b0, txOvf_q, rxOvf_q, rxEmpty, txFull, busy};
      3'd5:    rdData = rxEmpty ? 8'h00 : rxHead;
      3'd6:    rdData = {rxLvl, txLvl};
      3'd7:    rdData = irqRd;
      default: rdData = 8'h00;
    endcase
  end

`ifdef SPI_IRQ_EN
  logic [1:0] irqEn_q;
  logic       irq_q;
  assign irqRd   = {6'b0, irqEn_q};
  assign irq_out = irq_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      irqEn_q <= 2'b00;
      irq_q   <= 1'b0;
    end else begin
      if (wrStrobe && (bus.periph_addr_in == 3'd7))
        irqEn_q <= bus.periph_data_in[1:0];
      irq_q <= (irqEn_q[0] && !rxEmpty) || (irqEn_q[1] && txEmpty && (state_q == IDLE));
    end
  end
`else
  assign irqRd = 8'h00;
`endif

  always_ff @(posedge clk_in) begin
    if (txPush)
      txMem_q[txWr_q] <= bus.periph_data_in;
    if (rxPush)
      rxMem_q[rxWr_q] <= rxShift_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      div_q       <= '0;
      mode_q      <= 3'b000;
      cs_q        <= '1;
      rxOvf_q     <= 1'b0;
      txOvf_q     <= 1'b0;
      dataOut_q   <= 8'h00;
      dataValid_q <= 1'b0;
      txWr_q      <= '0;
      txRd_q      <= '0;
      txCount_q   <= '0;
      rxWr_q      <= '0;
      rxRd_q      <= '0;
      rxCount_q   <= '0;
    end else begin
      dataValid_q <= rdStrobe;
      if (rdStrobe)
        dataOut_q <= rdData;
      if (wrStrobe) begin
        case (bus.periph_addr_in)
          3'd0:    div_q  <= bus.periph_data_in[DIV_WIDTH-1:0];
          3'd1:    mode_q <= bus.periph_data_in[2:0];
          3'd2:    cs_q   <= bus.periph_data_in[CS_COUNT-1:0];
          default: ;
        endcase
      end
      // A new overflow in the same cycle as a clear wins, so no event is lost.
      if (txPushReq && txFull)
        txOvf_q <= 1'b1;
      else if (statusWr && bus.periph_data_in[4])
        txOvf_q <= 1'b0;
      if ((state_q == DONE) && rxFull)
        rxOvf_q <= 1'b1;
      else if (statusWr && bus.periph_data_in[3])
        rxOvf_q <= 1'b0;
      if (txPush)
        txWr_q <= txWr_q + 1'b1;
      if (txPop)
        txRd_q <= txRd_q + 1'b1;
      if (rxPush)
        rxWr_q <= rxWr_q + 1'b1;
      if (rxPop)
        rxRd_q <= rxRd_q + 1'b1;
      txCount_q <= txCount_d;
      rxCount_q <= rxCount_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      engDiv_q   <= '0;
      engMode_q  <= 3'b000;
      divCnt_q   <= '0;
      edgeCnt_q  <= 4'd0;
      txShift_q  <= 8'h00;
      rxShift_q  <= 8'h00;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      misoMeta_q <= 1'b0;
      misoSync_q <= 1'b0;
    end else begin
      misoMeta_q <= miso_in;
      misoSync_q <= misoMeta_q;
      case (state_q)
        IDLE: begin
          sclk_q <= mode_q[1];
          if (!txEmpty || txPush)
            state_q <= LOAD;
        end
        LOAD: begin
          engDiv_q  <= div_q;
          engMode_q <= mode_q;
          divCnt_q  <= '0;
          edgeCnt_q <= 4'd0;
          rxShift_q <= 8'h00;
          sclk_q    <= mode_q[1];
          // CPHA=0 must have the first bit on MOSI before the first edge.
          if (!mode_q[0]) begin
            mosi_q    <= mode_q[2] ? txHead[0] : txHead[7];
            txShift_q <= mode_q[2] ? {1'b0, txHead[7:1]} : {txHead[6:0], 1'b0};
          end else begin
            txShift_q <= txHead;
          end
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (divCnt_q == engDiv_q) begin
            divCnt_q  <= '0;
            sclk_q    <= ~sclk_q;
            edgeCnt_q <= edgeCnt_q + 4'd1;
            if (doSample)
              rxShift_q <= engMode_q[2] ? {misoSync_q, rxShift_q[7:1]}
                                        : {rxShift_q[6:0], misoSync_q};
            if (doShift) begin
              mosi_q    <= engMode_q[2] ? txShift_q[0] : txShift_q[7];
              txShift_q <= engMode_q[2] ? {1'b0, txShift_q[7:1]} : {txShift_q[6:0], 1'b0};
            end
            if (edgeCnt_q == 4'd15)
              state_q <= DONE;
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end
        DONE: begin
          sclk_q <= engMode_q[1];
          // Going straight to LOAD keeps the inter-byte gap at two clocks.
          state_q <= (!txEmpty || txPush) ? LOAD : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sclk_out                  = sclk_q;
  assign mosi_out                  = mosi_q;
  assign cs_out                    = cs_q;
  assign bus.periph_data_out       = dataOut_q;
  assign bus.periph_data_valid_out = dataValid_q;

endmodule
